wb_sram_sequencer: RTL and testbench

Wishbone-slave sequencer that converts single Wishbone transfers into correctly timed OpenRAM macro port cycles for bank A (256x32) and bank B (512x32). It sits directly upstream of the SRAM macros. It drives the shared addr/din/web/wmask/csb bundles and consumes the registered dout words returned by the top-level wrapper. A fixed-latency FSM hides the macro access time and the wrapper's extra dout register stage.

---
 rtl/wb_sram_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_wb_sram_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sram_sequencer.sv
// Wishbone slave that turns single transfers into fixed-latency OpenRAM port cycles for banks A and B.
// Define WRITE_VERIFY_EN to add a port1 read-back check after every SRAM write.
module wb_sram_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          A_AW      = 8,
  parameter int          B_AW      = 9,
  parameter int          RD_WAIT   = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  output logic [A_AW-1:0] addrA0,
  output logic [A_AW-1:0] addrA1,
  output logic [31:0]     dinA0,
  output logic            webA,
  output logic [3:0]      wmaskA,
  output logic            csbA0,
  output logic            csbA1,
  output logic [B_AW-1:0] addrB0,
  output logic [B_AW-1:0] addrB1,
  output logic [31:0]     dinB0,
  output logic            webB,
  output logic [3:0]      wmaskB,
  output logic            csbB0,
  output logic            csbB1,
  input  logic [31:0]     doutA0,
  input  logic [31:0]     doutA1,
  input  logic [31:0]     doutB0,
  input  logic [31:0]     doutB1,
  output logic [2:0]      user_irq,
  output logic [2:0]      dbg_state_o
);

  // Handshake: a request is cyc&stb sampled in IDLE while no ack is showing; ack is a
  // one-cycle registered pulse, and the master must drop stb the cycle after it sees ack.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_CAPT   = 3'd3,
    S_ACK    = 3'd4
`ifdef WRITE_VERIFY_EN
    , S_VISSUE = 3'd5
`endif
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(RD_WAIT - 2);

  state_t          state_q;
  logic [3:0]      wait_q;
  logic            is_rd_q, bank_b_q, ack_q, irq1_q;
  logic [31:0]     wbs_dat_q, dinA0_q, dinB0_q;
  logic [A_AW-1:0] addrA0_q;
  logic [B_AW-1:0] addrB0_q;
  logic [3:0]      wmaskA_q, wmaskB_q;
  logic            webA_q, webB_q, csbA0_q, csbB0_q;
  logic [7:0]      unm_cnt_q, err_cnt;
  logic            irq0;

  logic base_hit, hit_a, hit_b, hit_s, wr_nop;
  assign base_hit = (wbs_adr_i[31:16] == BASE_ADDR[31:16]);
  assign hit_a    = base_hit && (wbs_adr_i[15:10] == 6'd0);
  assign hit_b    = base_hit && (wbs_adr_i[15:11] == 5'b00010);
  assign hit_s    = base_hit && (wbs_adr_i[15:2] == 14'h0800);
  assign wr_nop   = wbs_we_i && (wbs_sel_i == 4'd0);

`ifdef WRITE_VERIFY_EN
  logic            verify_q, irq0_q, csbA1_q, csbB1_q;
  logic [7:0]      err_cnt_q;
  logic [A_AW-1:0] addrA1_q;
  logic [B_AW-1:0] addrB1_q;
  logic [3:0]      v_sel;
  logic [31:0]     v_mask, v_dout, v_din;
  logic            v_mism;
  assign v_sel  = bank_b_q ? wmaskB_q : wmaskA_q;
  assign v_mask = {{8{v_sel[3]}}, {8{v_sel[2]}}, {8{v_sel[1]}}, {8{v_sel[0]}}};
  assign v_dout = bank_b_q ? doutB1 : doutA1;
  assign v_din  = bank_b_q ? dinB0_q : dinA0_q;
  assign v_mism = |((v_dout ^ v_din) & v_mask);
  assign err_cnt = err_cnt_q;
  assign irq0    = irq0_q;
  assign csbA1   = csbA1_q;
  assign csbB1   = csbB1_q;
  assign addrA1  = addrA1_q;
  assign addrB1  = addrB1_q;
  logic unused_bits;
  assign unused_bits = ^wbs_adr_i[1:0];
`else
  assign err_cnt = 8'd0;
  assign irq0    = 1'b0;
  assign csbA1   = 1'b1;
  assign csbB1   = 1'b1;
  assign addrA1  = '0;
  assign addrB1  = '0;
  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i[1:0], doutA1, doutB1};
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;   wait_q <= 4'd0;    is_rd_q <= 1'b0;  bank_b_q <= 1'b0;
      ack_q <= 1'b0;       irq1_q <= 1'b0;    wbs_dat_q <= '0;  unm_cnt_q <= 8'd0;
      dinA0_q <= '0;       dinB0_q <= '0;     addrA0_q <= '0;   addrB0_q <= '0;
      wmaskA_q <= 4'd0;    wmaskB_q <= 4'd0;  webA_q <= 1'b1;   webB_q <= 1'b1;
      csbA0_q <= 1'b1;     csbB0_q <= 1'b1;
`ifdef WRITE_VERIFY_EN
      verify_q <= 1'b0;    irq0_q <= 1'b0;    err_cnt_q <= 8'd0;
      csbA1_q <= 1'b1;     csbB1_q <= 1'b1;   addrA1_q <= '0;   addrB1_q <= '0;
`endif
    end else begin
      ack_q  <= 1'b0;
      irq1_q <= 1'b0;
      if (state_q != S_IDLE && !wbs_cyc_i) begin
        // Abort: any chip select already issued finishes on its own edge.
        state_q <= S_IDLE;
        csbA0_q <= 1'b1; csbB0_q <= 1'b1; webA_q <= 1'b1; webB_q <= 1'b1;
`ifdef WRITE_VERIFY_EN
        csbA1_q <= 1'b1; csbB1_q <= 1'b1;
`endif
      end else begin
        case (state_q)
          S_IDLE: if (wbs_cyc_i && wbs_stb_i && !ack_q) begin
            is_rd_q  <= !wbs_we_i;
            bank_b_q <= hit_b;
`ifdef WRITE_VERIFY_EN
            verify_q <= 1'b0;
`endif
            if (hit_a && !wr_nop) begin
              addrA0_q <= wbs_adr_i[2 +: A_AW]; dinA0_q <= wbs_dat_i; wmaskA_q <= wbs_sel_i;
              webA_q   <= !wbs_we_i;            csbA0_q <= 1'b0;      state_q  <= S_ISSUE;
            end else if (hit_b && !wr_nop) begin
              addrB0_q <= wbs_adr_i[2 +: B_AW]; dinB0_q <= wbs_dat_i; wmaskB_q <= wbs_sel_i;
              webB_q   <= !wbs_we_i;            csbB0_q <= 1'b0;      state_q  <= S_ISSUE;
            end else begin
              state_q <= S_ACK;
              if (hit_s) begin
                if (!wbs_we_i) wbs_dat_q <= {16'd0, err_cnt, unm_cnt_q};
`ifdef WRITE_VERIFY_EN
                else irq0_q <= 1'b0;
`endif
              end else if (!hit_a && !hit_b) begin
                irq1_q <= 1'b1;
                if (unm_cnt_q != 8'hFF) unm_cnt_q <= unm_cnt_q + 8'd1;
                if (!wbs_we_i) wbs_dat_q <= 32'd0;
              end
            end
          end
          S_ISSUE: begin
            csbA0_q <= 1'b1; csbB0_q <= 1'b1; webA_q <= 1'b1; webB_q <= 1'b1;
            if (is_rd_q) begin
              if (RD_WAIT > 1) begin state_q <= S_WAIT; wait_q <= WAIT_INIT; end
              else state_q <= S_CAPT;
            end else begin
`ifdef WRITE_VERIFY_EN
              state_q  <= S_VISSUE;
              verify_q <= 1'b1;
              if (bank_b_q) begin addrB1_q <= addrB0_q; csbB1_q <= 1'b0; end
              else begin addrA1_q <= addrA0_q; csbA1_q <= 1'b0; end
`else
              state_q <= S_ACK;
`endif
            end
          end
`ifdef WRITE_VERIFY_EN
          S_VISSUE: begin
            csbA1_q <= 1'b1; csbB1_q <= 1'b1;
            if (RD_WAIT > 1) begin state_q <= S_WAIT; wait_q <= WAIT_INIT; end
            else state_q <= S_CAPT;
          end
`endif
          S_WAIT: begin
            if (wait_q == 4'd0) state_q <= S_CAPT;
            else wait_q <= wait_q - 4'd1;
          end
          S_CAPT: begin
            state_q <= S_ACK;
`ifdef WRITE_VERIFY_EN
            if (verify_q) begin
              if (v_mism) begin
                irq0_q <= 1'b1;
                if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
              end
            end else
`endif
            wbs_dat_q <= bank_b_q ? doutB0 : doutA0;
          end
          S_ACK: begin
            ack_q   <= 1'b1;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = wbs_dat_q;
  assign addrA0      = addrA0_q;
  assign dinA0       = dinA0_q;
  assign webA        = webA_q;
  assign wmaskA      = wmaskA_q;
  assign csbA0       = csbA0_q;
  assign addrB0      = addrB0_q;
  assign dinB0       = dinB0_q;
  assign webB        = webB_q;
  assign wmaskB      = wmaskB_q;
  assign csbB0       = csbB0_q;
  assign user_irq    = {1'b0, irq1_q, irq0};
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_sram_sequencer.sv
// Scoreboard bench for wb_sram_sequencer: SRAM macro + wrapper emulation, reference memory/counter model.
module tb_wb_sram_sequencer;

`ifdef WRITE_VERIFY_EN
  localparam int WR_LAT = 6;
`else
  localparam int WR_LAT = 3;
`endif
  localparam int RD_LAT = 5;
  localparam int SH_LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic [7:0]  addrA0, addrA1;
  logic [8:0]  addrB0, addrB1;
  logic [31:0] dinA0, dinB0;
  logic        webA, webB, csbA0, csbA1, csbB0, csbB1;
  logic [3:0]  wmaskA, wmaskB;
  logic [31:0] doutA0, doutA1, doutB0, doutB1;
  logic [2:0]  user_irq, dbg_state;

  wb_sram_sequencer dut (
    .clk(clk), .resetn(resetn), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .addrA0(addrA0), .addrA1(addrA1), .dinA0(dinA0), .webA(webA), .wmaskA(wmaskA),
    .csbA0(csbA0), .csbA1(csbA1), .addrB0(addrB0), .addrB1(addrB1), .dinB0(dinB0),
    .webB(webB), .wmaskB(wmaskB), .csbB0(csbB0), .csbB1(csbB1),
    .doutA0(doutA0), .doutA1(doutA1), .doutB0(doutB0), .doutB1(doutB1),
    .user_irq(user_irq), .dbg_state_o(dbg_state)
  );

  // ---------------- SRAM macro + wrapper register emulation ----------------
  logic [31:0] sram_a [256];
  logic [31:0] sram_b [512];
  logic [31:0] ref_a [256];
  logic [31:0] ref_b [512];
  logic        load_mem, force_p1;
  logic [31:0] a_m0, a_m1, b_m0, b_m1, dA1_r, dB1_r;
  logic [7:0]  last_a_addr;
  logic [8:0]  last_b_addr;

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) sram_a[i] = ref_a[i];
      for (int i = 0; i < 512; i++) sram_b[i] = ref_b[i];
    end
    if (!csbA0) begin
      last_a_addr <= addrA0;
      if (!webA) begin
        for (int i = 0; i < 4; i++) if (wmaskA[i]) sram_a[addrA0][8*i +: 8] = dinA0[8*i +: 8];
      end else a_m0 <= sram_a[addrA0];
    end
    if (!csbB0) begin
      last_b_addr <= addrB0;
      if (!webB) begin
        for (int i = 0; i < 4; i++) if (wmaskB[i]) sram_b[addrB0][8*i +: 8] = dinB0[8*i +: 8];
      end else b_m0 <= sram_b[addrB0];
    end
    if (!csbA1) a_m1 <= sram_a[addrA1];
    if (!csbB1) b_m1 <= sram_b[addrB1];
    doutA0 <= a_m0; dA1_r <= a_m1; doutB0 <= b_m0; dB1_r <= b_m1;
  end
  assign doutA1 = force_p1 ? 32'd0 : dA1_r;
  assign doutB1 = dB1_r;

  // ---------------- activity counters ----------------
  int cyc_cnt = 0, n_csa = 0, n_csb = 0, n_irq1 = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  always @(negedge clk) begin
    if (!csbA0) n_csa <= n_csa + 1;
    if (!csbB0) n_csb <= n_csb + 1;
    if (user_irq[1]) n_irq1 <= n_irq1 + 1;
  end

  // ---------------- scoreboard ----------------
  int checks = 0, failures = 0;
  logic [31:0] exp_q[$];
  bit          chk_q[$];
  int          lat_q[$];
  int          iss_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (ack) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL spurious_ack actual=1 expected=0 (t=%0t)", $time);
      end else begin
        logic [31:0] e; bit c; int l, s;
        e = exp_q.pop_front(); c = chk_q.pop_front(); l = lat_q.pop_front(); s = iss_q.pop_front();
        chk("ack_latency", 32'(cyc_cnt - s), 32'(l));
        if (c) chk("read_data", rdat, e);
      end
    end
  end

  // ---------------- reference model state ----------------
  logic [7:0] m_unm, m_err;
  logic       m_irq0;

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [15:0] off; logic [31:0] m, e; bit c, seen; int l, ea, eb, ei, ca, cb, ci;
    off = a[15:0];
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    e = 32'd0; c = 1'b0; l = SH_LAT; ea = 0; eb = 0; ei = 0;
    if (a[31:16] == 16'h3000 && off < 16'h0400) begin
      if (!w) begin e = ref_a[off[9:2]]; c = 1'b1; l = RD_LAT; ea = 1; end
      else if (s != 4'd0) begin
        ref_a[off[9:2]] = (ref_a[off[9:2]] & ~m) | (d & m); l = WR_LAT; ea = 1;
`ifdef WRITE_VERIFY_EN
        if (force_p1 && ((d & m) != 32'd0)) begin
          m_irq0 = 1'b1; if (m_err != 8'hFF) m_err = m_err + 8'd1;
        end
`endif
      end
    end else if (a[31:16] == 16'h3000 && off >= 16'h1000 && off < 16'h1800) begin
      if (!w) begin e = ref_b[off[10:2]]; c = 1'b1; l = RD_LAT; eb = 1; end
      else if (s != 4'd0) begin
        ref_b[off[10:2]] = (ref_b[off[10:2]] & ~m) | (d & m); l = WR_LAT; eb = 1;
      end
    end else if (a[31:16] == 16'h3000 && off[15:2] == 14'h0800) begin
      if (!w) begin e = {16'd0, m_err, m_unm}; c = 1'b1; end
      else m_irq0 = 1'b0;
    end else begin
      ei = 1;
      if (!w) c = 1'b1;
      if (m_unm != 8'hFF) m_unm = m_unm + 8'd1;
    end
    ca = n_csa; cb = n_csb; ci = n_irq1;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    exp_q.push_back(e); chk_q.push_back(c); lat_q.push_back(l); iss_q.push_back(cyc_cnt);
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (ack) seen = 1'b1;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL ack_timeout actual=0 expected=1 addr=%h", a);
      if (exp_q.size() > 0) begin
        void'(exp_q.pop_front()); void'(chk_q.pop_front());
        void'(lat_q.pop_front()); void'(iss_q.pop_front());
      end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("csbA0_low_cycles", 32'(n_csa - ca), 32'(ea));
    chk("csbB0_low_cycles", 32'(n_csb - cb), 32'(eb));
    chk("irq1_pulse_cycles", 32'(n_irq1 - ci), 32'(ei));
    chk("irq0", 32'(user_irq[0]), 32'(m_irq0));
  endtask

  // Starts a bank A read and kills it while the FSM is waiting for dout.
  task automatic abort_read(input logic [31:0] a, input bit by_reset);
    int ca;
    ca = n_csa;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (by_reset) begin
      resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      m_unm = 8'd0; m_err = 8'd0; m_irq0 = 1'b0;
    end
    cyc = 1'b0; stb = 1'b0;
    repeat (4) @(negedge clk);
    chk(by_reset ? "state_after_reset_abort" : "state_after_cyc_abort", 32'(dbg_state), 32'd0);
    chk("abort_csbA0_cycles", 32'(n_csa - ca), 32'd1);
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k <= 3)      return 32'h3000_0000 | (32'($urandom_range(0, 255)) << 2);
    else if (k <= 6) return 32'h3000_1000 | (32'($urandom_range(0, 511)) << 2);
    else if (k == 7) return 32'h3000_2000;
    else if (k == 8) return 32'h3000_0400 + (32'($urandom_range(0, 767)) << 2);
    else             return 32'h4000_0000 | (32'($urandom_range(0, 1023)) << 2);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'd0; adr = '0; wdat = '0;
    force_p1 = 1'b0; load_mem = 1'b1;
    m_unm = 8'd0; m_err = 8'd0; m_irq0 = 1'b0;
    for (int i = 0; i < 256; i++) ref_a[i] = $urandom;
    for (int i = 0; i < 512; i++) ref_b[i] = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    load_mem = 1'b0;
    chk("rst_csb", 32'({csbA0, csbA1, csbB0, csbB1}), 32'hF);
    chk("rst_web", 32'({webA, webB}), 32'h3);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", rdat, 32'd0);
    chk("rst_irq", 32'(user_irq), 32'd0);
    chk("rst_wmask_addr", 32'({wmaskA, wmaskB, addrA0, addrB0}), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    begin
      int ca, cb;
      ca = n_csa; cb = n_csb;
      repeat (5) @(negedge clk);
      chk("idle_no_sram_activity", 32'((n_csa - ca) + (n_csb - cb)), 32'd0);
    end

    xfer(1'b1, 32'h3000_0010, 32'hA5A5_1234, 4'hF);
    chk("write_addrA0", 32'(last_a_addr), 32'd4);
    xfer(1'b0, 32'h3000_0010, 32'd0, 4'hF);
    xfer(1'b0, 32'h3000_17FC, 32'd0, 4'hF);
    chk("read_addrB0", 32'(last_b_addr), 32'd511);
    xfer(1'b0, 32'h3000_0800, 32'd0, 4'hF);
    xfer(1'b0, 32'h3000_2000, 32'd0, 4'hF);
    xfer(1'b1, 32'h3000_0020, 32'h1234_5678, 4'h0);

    abort_read(32'h3000_0040, 1'b0);
    xfer(1'b0, 32'h3000_0044, 32'd0, 4'hF);
    abort_read(32'h3000_0048, 1'b1);
    xfer(1'b0, 32'h3000_104C, 32'd0, 4'hF);
    xfer(1'b0, 32'h3000_2000, 32'd0, 4'hF);

`ifdef WRITE_VERIFY_EN
    force_p1 = 1'b1;
    xfer(1'b1, 32'h3000_0030, 32'hFFFF_FFFF, 4'h1);
    force_p1 = 1'b0;
    xfer(1'b0, 32'h3000_2000, 32'd0, 4'hF);
    xfer(1'b1, 32'h3000_2000, 32'd0, 4'hF);
`endif

    for (int n = 0; n < 80; n++) begin
      xfer(1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(0, 15)));
    end
    xfer(1'b0, 32'h3000_2000, 32'd0, 4'hF);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
